// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump engine.
// The CSUM state is only reached when REGDUMP_CHECKSUM_EN is defined.
package regdump_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4
  } regdump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: while the core is halted, walks register indices
// 0..NREGS-1 over a spare combinational read port and streams each value
// over a valid/ready interface.
// Optional feature macro: REGDUMP_CHECKSUM_EN appends an XOR checksum beat.
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = DEF_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halted,
  output logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  // The counter is one bit wider than the index so that NREGS == 2**AW
  // reaches its last value without wrapping.
  localparam int CW = AW + 1;
  localparam logic [AW:0] LAST_CNT = CW'(NREGS - 1);
  localparam logic [AW:0] CNT_ONE  = CW'(1);

  regdump_state_t  state_r;
  logic [AW:0]     cnt_r;
  logic [AW-1:0]   rd_addr_r;
  logic            out_valid_r;
  logic [XLEN-1:0] out_data_r;
  logic [AW-1:0]   out_idx_r;
  logic            out_last_r;
  logic            busy_r;
  logic            done_r;
  logic            hs_s;
  logic [AW:0]     cnt_next_s;

`ifdef REGDUMP_CHECKSUM_EN
  logic [XLEN-1:0] csum_r;

  // Running checksum: XOR-fold of every accepted register beat.
  function automatic logic [XLEN-1:0] csum_fold(input logic [XLEN-1:0] acc,
                                                input logic [XLEN-1:0] beat);
    return acc ^ beat;
  endfunction
`endif

  assign hs_s       = out_valid_r & out_ready;
  assign cnt_next_s = cnt_r + CNT_ONE;

  assign rd_addr   = rd_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Dump FSM with registered outputs; the handshake only moves state, so
  // nothing on the output side depends combinationally on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      rd_addr_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_r      <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && halted) begin
            cnt_r     <= '0;
            rd_addr_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= ST_FETCH;
`ifdef REGDUMP_CHECKSUM_EN
            csum_r    <= '0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          out_data_r  <= rd_data;
          out_idx_r   <= cnt_r[AW-1:0];
`ifdef REGDUMP_CHECKSUM_EN
          out_last_r  <= 1'b0;
`else
          out_last_r  <= (cnt_r == LAST_CNT);
`endif
          out_valid_r <= 1'b1;
          state_r     <= ST_SEND;
        end
        ST_SEND: begin
          if (hs_s) begin
            if (cnt_r < LAST_CNT) begin
              cnt_r       <= cnt_next_s;
              rd_addr_r   <= cnt_next_s[AW-1:0];
              out_valid_r <= 1'b0;
              state_r     <= ST_FETCH;
`ifdef REGDUMP_CHECKSUM_EN
              csum_r      <= csum_fold(csum_r, out_data_r);
`endif
            end else begin
`ifdef REGDUMP_CHECKSUM_EN
              // Fold the final register into the checksum beat directly.
              csum_r     <= csum_fold(csum_r, out_data_r);
              out_data_r <= csum_fold(csum_r, out_data_r);
              out_idx_r  <= '0;
              out_last_r <= 1'b1;
              state_r    <= ST_CSUM;
`else
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= ST_DONE;
`endif
            end
          end else begin
            state_r <= ST_SEND;
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (hs_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            state_r <= ST_CSUM;
          end
        end
`endif
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump with a scoreboard of expected beats.
// Honours REGDUMP_CHECKSUM_EN for the extra checksum beat.
module tb_regfile_dump;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halted;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];

  int total;
  int bad;
  int done_cyc;
  int done_cnt;
  int stall_cnt;
  int stab_bad;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int NBEATS = 33;
  localparam int DONE_CYCLE = 66;
`else
  localparam int NBEATS = 32;
  localparam int DONE_CYCLE = 65;
`endif

  regfile_dump dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halted    (halted),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Combinational register-file read port model.
  assign rd_data = regs[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push the expected beat sequence for the current register contents.
  task automatic push_expected();
    beat_t b;
    logic [31:0] csum;
    csum = 32'h0;
    for (int i = 0; i < 32; i++) begin
      b.data = regs[i];
      b.idx  = i[4:0];
`ifdef REGDUMP_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (i == 31);
`endif
      csum = csum ^ regs[i];
      exp_q.push_back(b);
    end
`ifdef REGDUMP_CHECKSUM_EN
    b.data = csum;
    b.idx  = 5'd0;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  // Start a dump and record accepted beats, done timing and stall stability.
  // ready_mode 0: always ready; 1: ready one cycle in three.
  task automatic run_dump(input int ready_mode, input bit busy_starts, input int max_cycles);
    beat_t cur;
    beat_t held;
    bit    stalled;
    int    tail;
    obs_q.delete();
    obs_cyc.delete();
    done_cyc  = -1;
    done_cnt  = 0;
    stall_cnt = 0;
    stab_bad  = 0;
    stalled   = 1'b0;
    tail      = -1;
    held      = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= max_cycles; cyc++) begin
      @(negedge clk);
      out_ready = (ready_mode == 1) ? (cyc % 3 == 0) : 1'b1;
      if (busy_starts) begin
        start = (cyc % 7 == 3) && (cyc < 30);
        if (cyc == 30) halted = 1'b0;
      end
      cur = {out_data, out_idx, out_last};
      if (stalled) begin
        stall_cnt++;
        if (!out_valid || cur !== held) stab_bad++;
      end
      stalled = out_valid && !out_ready;
      held    = cur;
      if (out_valid && out_ready) begin
        obs_q.push_back(cur);
        obs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          tail = cyc + 4;
        end
      end
      if (tail >= 0 && cyc >= tail) break;
    end
    start  = 1'b0;
    halted = 1'b1;
  endtask

  task automatic preload_ramp();
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : (32'h1000 + i);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (rd_addr !== 5'd0)    begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h0)  begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (out_idx !== 5'd0)    begin bad++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
    total++; if (out_last !== 1'b0)   begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dump_basic();
    beat_t e;
    beat_t o;
    int    k;
    preload_ramp();
    push_expected();
    run_dump(0, 1'b0, 200);
    total++; if (obs_q.size() !== NBEATS) begin bad++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), NBEATS); end
    for (k = 0; k < 32 && k < obs_cyc.size(); k++) begin
      total++;
      if (obs_cyc[k] !== 2 + 2 * k) begin bad++; $display("FAIL basic_beat_cycle k=%0d got=%0d want=%0d", k, obs_cyc[k], 2 + 2 * k); end
    end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL basic_beat n=%0d got=%h/%0d/%b want=%h/%0d/%b", k, o.data, o.idx, o.last, e.data, e.idx, e.last); end
      k++;
    end
    exp_q.delete();
    total++; if (done_cyc !== DONE_CYCLE) begin bad++; $display("FAIL basic_done_cycle got=%0d want=%0d", done_cyc, DONE_CYCLE); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_width got=%0d want=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_backpressure();
    beat_t e;
    beat_t o;
    int    k;
    preload_ramp();
    push_expected();
    run_dump(1, 1'b0, 500);
    total++; if (obs_q.size() !== NBEATS) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), NBEATS); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL bp_beat n=%0d got=%h/%0d/%b want=%h/%0d/%b", k, o.data, o.idx, o.last, e.data, e.idx, e.last); end
      k++;
    end
    exp_q.delete();
    total++; if (stall_cnt < 10) begin bad++; $display("FAIL bp_stalls got=%0d want>=10", stall_cnt); end
    total++; if (stab_bad !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stab_bad); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_not_halted();
    bit seen;
    seen = 1'b0;
    halted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy || out_valid || done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL not_halted_activity got=%b want=0", seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL not_halted_busy got=%b want=0", busy); end
    halted = 1'b1;
  endtask

  task automatic test_start_while_busy();
    beat_t e;
    beat_t o;
    int    k;
    preload_ramp();
    push_expected();
    run_dump(0, 1'b1, 200);
    total++; if (obs_q.size() !== NBEATS) begin bad++; $display("FAIL busy_count got=%0d want=%0d", obs_q.size(), NBEATS); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL busy_beat n=%0d got=%h/%0d/%b want=%h/%0d/%b", k, o.data, o.idx, o.last, e.data, e.idx, e.last); end
      k++;
    end
    exp_q.delete();
    total++; if (done_cyc !== DONE_CYCLE) begin bad++; $display("FAIL busy_done_cycle got=%0d want=%0d", done_cyc, DONE_CYCLE); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit found;
    bit seen;
    beat_t e;
    beat_t o;
    found = 1'b0;
    seen  = 1'b0;
    preload_ramp();
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (out_valid && out_idx == 5'd10) begin
        found = 1'b1;
        out_ready = 1'b0;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rstmid_reach_idx10 got=%b want=1", found); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rstmid_out_data got=%h want=0", out_data); end
    total++; if (out_idx !== 5'd0)   begin bad++; $display("FAIL rstmid_out_idx got=%0d want=0", out_idx); end
    total++; if (rd_addr !== 5'd0)   begin bad++; $display("FAIL rstmid_rd_addr got=%0d want=0", rd_addr); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done || out_valid || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%b want=0", seen); end
    push_expected();
    run_dump(0, 1'b0, 200);
    total++; if (obs_q.size() !== NBEATS) begin bad++; $display("FAIL rstmid_redump_count got=%0d want=%0d", obs_q.size(), NBEATS); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL rstmid_redump_beat got=%h/%0d/%b want=%h/%0d/%b", o.data, o.idx, o.last, e.data, e.idx, e.last); end
    end
    exp_q.delete();
  endtask

  task automatic test_checksum();
    beat_t e;
    beat_t o;
    int    k;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'hFFFF_FFFF;
    push_expected();
    run_dump(0, 1'b0, 200);
    total++; if (obs_q.size() !== NBEATS) begin bad++; $display("FAIL csum_count got=%0d want=%0d", obs_q.size(), NBEATS); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL csum_beat n=%0d got=%h/%0d/%b want=%h/%0d/%b", k, o.data, o.idx, o.last, e.data, e.idx, e.last); end
      k++;
    end
    exp_q.delete();
    total++; if (done_cyc !== DONE_CYCLE) begin bad++; $display("FAIL csum_done_cycle got=%0d want=%0d", done_cyc, DONE_CYCLE); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    halted    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_dump_basic();
    test_backpressure();
    test_not_halted();
    test_start_while_busy();
    test_reset_mid();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
